// File: rtl/fifo_1r1w_ctrl_if.sv
// Handshake and storage-control bundle between a 1R1W FIFO controller and
// its producer/consumer/storage; widths follow the entry count.
interface fifo_1r1w_ctrl_if #(
  parameter int els_p = 4
);
  localparam int ptr_width_lp   = $clog2(els_p);
  localparam int count_width_lp = $clog2(els_p + 1);

  logic                      valid_i;
  logic                      ready_o;
  logic                      valid_o;
  logic                      yumi_i;
  logic [els_p-1:0]          wr_en_o;
  logic [ptr_width_lp-1:0]   rd_sel_o;
  logic [count_width_lp-1:0] count_o;
  logic                      full_o;
  logic                      empty_o;

  modport master (
    output valid_i, yumi_i,
    input  ready_o, valid_o, wr_en_o, rd_sel_o, count_o, full_o, empty_o
  );

  modport slave (
    input  valid_i, yumi_i,
    output ready_o, valid_o, wr_en_o, rd_sel_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/fifo_1r1w_ctrl.sv
// Pointer/occupancy controller for a one-read/one-write FIFO: drives one-hot
// write enables and the read-mux select; holds no data.
module fifo_1r1w_ctrl #(
  parameter int els_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  fifo_1r1w_ctrl_if.slave    bus
);
  localparam int ptr_width_lp   = $clog2(els_p);
  localparam int count_width_lp = $clog2(els_p + 1);

  logic [ptr_width_lp-1:0]   r_wptr;
  logic [ptr_width_lp-1:0]   r_rptr;
  logic [count_width_lp-1:0] r_count;

  logic                      w_full;
  logic                      w_empty;
  logic                      w_enq;
  logic                      w_deq;
  logic [ptr_width_lp-1:0]   w_wptr_nxt;
  logic [ptr_width_lp-1:0]   w_rptr_nxt;
  logic [els_p-1:0]          w_wr_en;

  assign w_full  = (r_count == count_width_lp'(els_p));
  assign w_empty = (r_count == '0);

  // reset_n_i gates enq so no write strobe escapes while reset is asserted
  assign w_enq = bus.valid_i & ~w_full & reset_n_i;
  assign w_deq = bus.yumi_i & ~w_empty;

  // Explicit wrap: els_p need not be a power of two
  assign w_wptr_nxt = (r_wptr == ptr_width_lp'(els_p - 1)) ? '0 : r_wptr + ptr_width_lp'(1);
  assign w_rptr_nxt = (r_rptr == ptr_width_lp'(els_p - 1)) ? '0 : r_rptr + ptr_width_lp'(1);

  always_comb begin
    w_wr_en = '0;
    if (w_enq) w_wr_en = {{(els_p-1){1'b0}}, 1'b1} << r_wptr;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= w_wptr_nxt;
      if (w_deq) r_rptr <= w_rptr_nxt;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + count_width_lp'(1);
        2'b01:   r_count <= r_count - count_width_lp'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.ready_o  = ~w_full;
  assign bus.valid_o  = ~w_empty;
  assign bus.full_o   = w_full;
  assign bus.empty_o  = w_empty;
  assign bus.count_o  = r_count;
  assign bus.rd_sel_o = r_rptr;
  assign bus.wr_en_o  = w_wr_en;

  a_no_yumi_when_empty: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) !(bus.yumi_i && w_empty));

  a_count_matches_ptrs: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (r_count == count_width_lp'(els_p)) ? (r_wptr == r_rptr)
      : (int'(r_count) == ((int'(r_wptr) - int'(r_rptr) + els_p) % els_p)));
endmodule
